// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic pipeline stage register with a valid/ready
// handshake, a 2-entry skid buffer (main + skid) and a synchronous flush.
// The control bundle is forced to zero whenever the main entry is invalid.
// The data bundle is held, and only reset clears it.
// Optional macro PIPE_STAGE_PERF_EN adds saturating stall/bubble counters.
module pipe_stage_reg #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 143,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  bubble_count
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_out_valid;
    logic                r_in_ready;
    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [DATA_W-1:0]   r_main_data;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [DATA_W-1:0]   r_skid_data;

    logic                w_accept;
    logic                w_drain;
    logic                w_main_load_in;
    logic                w_main_load_skid;
    logic                w_main_clear;
    logic                w_skid_load;

    assign w_accept = in_valid & r_in_ready;
    assign w_drain  = r_out_valid & out_ready;

    // Next-state and datapath load selection; flush overrides everything.
    always_comb begin
        w_state_next     = r_state;
        w_main_load_in   = 1'b0;
        w_main_load_skid = 1'b0;
        w_main_clear     = 1'b0;
        w_skid_load      = 1'b0;
        if (flush) begin
            w_state_next = ST_EMPTY;
            w_main_clear = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_next   = ST_ONE;
                        w_main_load_in = 1'b1;
                    end else begin
                        w_state_next = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_drain) begin
                        w_state_next   = ST_ONE;
                        w_main_load_in = 1'b1;
                    end else if (w_accept) begin
                        w_state_next = ST_FULL;
                        w_skid_load  = 1'b1;
                    end else if (w_drain) begin
                        w_state_next = ST_EMPTY;
                        w_main_clear = 1'b1;
                    end else begin
                        w_state_next = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (w_drain) begin
                        w_state_next     = ST_ONE;
                        w_main_load_skid = 1'b1;
                    end else begin
                        w_state_next = ST_FULL;
                    end
                end
                default: begin
                    w_state_next = ST_EMPTY;
                    w_main_clear = 1'b1;
                end
            endcase
        end
    end

    // State register plus registered handshake outputs derived from next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_out_valid <= (w_state_next != ST_EMPTY);
            r_in_ready  <= (w_state_next != ST_FULL);
        end
    end

    // Main entry: load from input or skid; an invalidated entry zeroes only ctrl.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_main_ctrl <= {CTRL_W{1'b0}};
            r_main_data <= {DATA_W{1'b0}};
        end else if (w_main_load_in) begin
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
        end else if (w_main_load_skid) begin
            r_main_ctrl <= r_skid_ctrl;
            r_main_data <= r_skid_data;
        end else if (w_main_clear) begin
            r_main_ctrl <= {CTRL_W{1'b0}};
        end else begin
            r_main_ctrl <= r_main_ctrl;
        end
    end

    // Skid entry: captures the in-flight entry that arrives while main stalls.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_skid_ctrl <= {CTRL_W{1'b0}};
            r_skid_data <= {DATA_W{1'b0}};
        end else if (w_skid_load) begin
            r_skid_ctrl <= in_ctrl;
            r_skid_data <= in_data;
        end else begin
            r_skid_ctrl <= r_skid_ctrl;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_ctrl  = r_main_ctrl;
    assign out_data  = r_main_data;

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_bubble_count;

    // Saturating stall/bubble counters; only reset clears them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall_count  <= {CNT_W{1'b0}};
            r_bubble_count <= {CNT_W{1'b0}};
        end else begin
            if (r_out_valid && !out_ready && (r_stall_count != {CNT_W{1'b1}})) begin
                r_stall_count <= r_stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_stall_count <= r_stall_count;
            end
            if (!r_out_valid && out_ready && (r_bubble_count != {CNT_W{1'b1}})) begin
                r_bubble_count <= r_bubble_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_bubble_count <= r_bubble_count;
            end
        end
    end

    assign stall_count  = r_stall_count;
    assign bubble_count = r_bubble_count;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_pipe_stage_reg;

    localparam int CW   = 16;
    localparam int DW   = 143;
    localparam int CNTW = 4;
    localparam int QMAX = 2;

    logic           clock = 1'b0;
    logic           reset;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [CW-1:0]  in_ctrl;
    logic [DW-1:0]  in_data;
    logic           out_valid;
    logic           out_ready;
    logic [CW-1:0]  out_ctrl;
    logic [DW-1:0]  out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [CNTW-1:0] stall_count;
    logic [CNTW-1:0] bubble_count;
`endif

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(CNTW)) dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_ctrl      (in_ctrl),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ctrl     (out_ctrl),
        .out_data     (out_data)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_count  (stall_count),
        .bubble_count (bubble_count)
`endif
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: FIFO of at most two entries plus the last shown data.
    logic [CW-1:0] q_ctrl[$];
    logic [DW-1:0] q_data[$];
    logic [DW-1:0] m_data;
    int            m_stall;
    int            m_bubble;
    int            sat_max;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        q_ctrl.delete();
        q_data.delete();
        m_data   = '0;
        m_stall  = 0;
        m_bubble = 0;
    endfunction

    // One clock edge of the model, using the inputs currently driven.
    function automatic void model_step();
        bit mv  = (q_ctrl.size() > 0);
        bit acc = in_valid && (q_ctrl.size() < QMAX);
        bit drn = mv && out_ready;
        if (mv && !out_ready && m_stall < sat_max) m_stall++;
        if (!mv && out_ready && m_bubble < sat_max) m_bubble++;
        if (flush) begin
            q_ctrl.delete();
            q_data.delete();
        end else begin
            if (drn) begin
                void'(q_ctrl.pop_front());
                void'(q_data.pop_front());
            end
            if (acc) begin
                q_ctrl.push_back(in_ctrl);
                q_data.push_back(in_data);
            end
        end
        if (q_data.size() > 0) m_data = q_data[0];
    endfunction

    task automatic check_all(input string tag);
        bit mv = (q_ctrl.size() > 0);
        check({tag, ".out_valid"}, {255'd0, out_valid}, {255'd0, mv});
        check({tag, ".in_ready"}, {255'd0, in_ready}, {255'd0, (q_ctrl.size() < QMAX)});
        check({tag, ".out_ctrl"}, {240'd0, out_ctrl}, mv ? {240'd0, q_ctrl[0]} : 256'd0);
        check({tag, ".out_data"}, {113'd0, out_data}, {113'd0, m_data});
`ifdef PIPE_STAGE_PERF_EN
        check({tag, ".stall_count"}, {252'd0, stall_count}, 256'(m_stall));
        check({tag, ".bubble_count"}, {252'd0, bubble_count}, 256'(m_bubble));
`endif
    endtask

    // Drive at negedge, advance the model at posedge, check at next negedge.
    task automatic step(input string tag, input logic iv, input logic [CW-1:0] ic,
                        input logic [DW-1:0] id, input logic ordy, input logic fl);
        in_valid  = iv;
        in_ctrl   = ic;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    initial begin
        sat_max = (1 << CNTW) - 1;
        do_reset();

        // Back-to-back stream with no backpressure.
        step("stream1", 1'b1, 16'h0011, 143'd1, 1'b1, 1'b0);
        step("stream2", 1'b1, 16'h0022, 143'd2, 1'b1, 1'b0);
        step("stream3", 1'b1, 16'h0033, 143'd3, 1'b1, 1'b0);
        // Idle: bubbles, ctrl reads zero.
        for (int i = 0; i < 5; i++) step("idle", 1'b0, 16'hFFFF, 143'd9, 1'b1, 1'b0);

        // Stall: A held, B absorbed by skid, then released in order.
        step("stallA", 1'b1, 16'h00A0, 143'hA, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("stallB", 1'b1, 16'h00B0, 143'hB, 1'b0, 1'b0);
        step("releaseA", 1'b0, 16'h0, 143'd0, 1'b1, 1'b0);
        step("releaseB", 1'b0, 16'h0, 143'd0, 1'b1, 1'b0);
        step("drained", 1'b0, 16'h0, 143'd0, 1'b1, 1'b0);

        // Flush in FULL with C offered: all three discarded.
        step("fillA", 1'b1, 16'h00A1, 143'hA1, 1'b0, 1'b0);
        step("fillB", 1'b1, 16'h00B1, 143'hB1, 1'b0, 1'b0);
        step("flushC", 1'b1, 16'h00C1, 143'hC1, 1'b0, 1'b1);
        step("postflush", 1'b0, 16'h0, 143'd0, 1'b1, 1'b0);

        // Asynchronous reset while FULL.
        step("fullA", 1'b1, 16'h00AA, 143'hAA, 1'b0, 1'b0);
        step("fullB", 1'b1, 16'h00AB, 143'hAA, 1'b0, 1'b0);
        #2;
        do_reset();
        step("postrst", 1'b1, 16'h0077, 143'h77, 1'b1, 1'b0);

        // Long stall to saturate the stall counter.
        for (int i = 0; i < 20; i++) step("satstall", 1'b0, 16'h0, 143'd0, 1'b0, 1'b0);
        step("satdrain", 1'b0, 16'h0, 143'd0, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step("rand", 1'($urandom_range(0, 1)), 16'($urandom), rand_data(),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
